// File: rtl/hazard_ctrl.sv
// IF/ID and PC hazard controller: load-use stalls, multi-cycle execute stalls,
// memory-wait freezes and taken-branch flushes. Define HAZ_PERF_CNT_EN for stall/flush counters.
module hazard_ctrl #(
    parameter int MC_CYCLES = 4,
    parameter int REG_AW    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              id_mc_op,
    input  logic              ex_branch_taken,
    input  logic              mem_wait,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
`ifdef HAZ_PERF_CNT_EN
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt,
`endif
    output logic [1:0]        ctrl_state
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MC_STALL = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    localparam logic [3:0] MC_INIT = 4'(MC_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] mc_cnt_q, mc_cnt_d;
    logic       load_use;

    always_comb begin
        load_use = ex_mem_read && (ex_rd != '0) &&
                   ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    end

    // Priority: reset > mem_wait > branch > stall/flush state > load-use > mc issue.
    always_comb begin
        state_d      = state_q;
        mc_cnt_d     = mc_cnt_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;

        if (!rst_n) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            state_d      = RUN;
            mc_cnt_d     = '0;
        end else if (mem_wait) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
        end else if (ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            state_d      = FLUSH;
            mc_cnt_d     = '0;
        end else begin
            case (state_q)
                MC_STALL: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    if (mc_cnt_q == '0) begin
                        state_d = RUN;
                    end else begin
                        mc_cnt_d = mc_cnt_q - 4'd1;
                    end
                end
                FLUSH: begin
                    if_id_flush = 1'b1;
                    state_d     = RUN;
                end
                RUN: begin
                    if (load_use) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                    end else if (id_mc_op) begin
                        state_d  = MC_STALL;
                        mc_cnt_d = MC_INIT;
                    end
                end
                default: begin
                    state_d  = RUN;
                    mc_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= RUN;
            mc_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            mc_cnt_q <= mc_cnt_d;
        end
    end

    assign ctrl_state = state_q;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_write) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (if_id_flush) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MC_CYCLES=4); inputs change on
// negedge and outputs are checked 1 time unit later, before the next posedge.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       ex_mem_read;
    logic [4:0] ex_rd;
    logic       id_mc_op;
    logic       ex_branch_taken;
    logic       mem_wait;
    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_ex_bubble;
    logic [1:0] ctrl_state;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    int nChecks = 0;
    int nFails  = 0;

    hazard_ctrl #(.MC_CYCLES(4), .REG_AW(5)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .id_mc_op        (id_mc_op),
        .ex_branch_taken (ex_branch_taken),
        .mem_wait        (mem_wait),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .if_id_flush     (if_id_flush),
        .id_ex_bubble    (id_ex_bubble),
`ifdef HAZ_PERF_CNT_EN
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
`endif
        .ctrl_state      (ctrl_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs at the negedge, then settle before checking.
    task automatic applyStimulus(input logic rst, input logic mw, input logic br,
                                 input logic mc, input logic mr, input logic [4:0] rd,
                                 input logic [4:0] rs, input logic [4:0] rt, input logic ur);
        @(negedge clk);
        rst_n           = rst;
        mem_wait        = mw;
        ex_branch_taken = br;
        id_mc_op        = mc;
        ex_mem_read     = mr;
        ex_rd           = rd;
        id_rs           = rs;
        id_rt           = rt;
        id_uses_rt      = ur;
        #1;
    endtask

    task automatic quiet();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic checkOutput(input string tag, input logic pc, input logic ifid,
                               input logic fl, input logic bub, input logic [1:0] st);
        nChecks++;
        assert (pc_write === pc) else begin
            nFails++;
            $error("[TB] FAIL %s pc_write observed=%b expected=%b", tag, pc_write, pc);
        end
        nChecks++;
        assert (if_id_write === ifid) else begin
            nFails++;
            $error("[TB] FAIL %s if_id_write observed=%b expected=%b", tag, if_id_write, ifid);
        end
        nChecks++;
        assert (if_id_flush === fl) else begin
            nFails++;
            $error("[TB] FAIL %s if_id_flush observed=%b expected=%b", tag, if_id_flush, fl);
        end
        nChecks++;
        assert (id_ex_bubble === bub) else begin
            nFails++;
            $error("[TB] FAIL %s id_ex_bubble observed=%b expected=%b", tag, id_ex_bubble, bub);
        end
        nChecks++;
        assert (ctrl_state === st) else begin
            nFails++;
            $error("[TB] FAIL %s ctrl_state observed=%0d expected=%0d", tag, ctrl_state, st);
        end
    endtask

    initial begin
        rst_n = 1'b0; mem_wait = 1'b0; ex_branch_taken = 1'b0; id_mc_op = 1'b0;
        ex_mem_read = 1'b0; ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;

        // Reset held two cycles, then release
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        checkOutput("reset1", 1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        checkOutput("reset2", 1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
        quiet();
        checkOutput("idle_after_reset", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);

        // Load-use on rs, on rt, rt ignored, and register 0
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
        checkOutput("lu_rs", 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
        quiet();
        checkOutput("lu_rs_next", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1);
        checkOutput("lu_rt", 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0);
        checkOutput("lu_rt_unused", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
        checkOutput("lu_r0", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd5, 5'd0, 1'b0);
        checkOutput("no_load", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);

        // Multi-cycle op: issue normal, then exactly 4 stall cycles
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        checkOutput("mc_issue", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 4; i++) begin
            quiet();
            checkOutput($sformatf("mc_stall%0d", i), 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
        end
        quiet();
        checkOutput("mc_done", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);

        // Load-use and mc op together: load-use wins, mc op issues next cycle
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0);
        checkOutput("lu_vs_mc", 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd4, 5'd0, 1'b0);
        checkOutput("mc_reissue", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
        quiet();
        checkOutput("mc_b_stall0", 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);

        // Branch during second stall cycle cancels the stall
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        checkOutput("br_in_stall", 1'b1, 1'b1, 1'b1, 1'b1, 2'd1);
        quiet();
        checkOutput("br_in_stall_flush", 1'b1, 1'b1, 1'b1, 1'b0, 2'd2);
        quiet();
        checkOutput("br_in_stall_run", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);

        // Branch in RUN
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        checkOutput("br_run", 1'b1, 1'b1, 1'b1, 1'b1, 2'd0);
        quiet();
        checkOutput("br_run_flush", 1'b1, 1'b1, 1'b1, 1'b0, 2'd2);
        quiet();
        checkOutput("br_run_done", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);

        // FLUSH deferred by mem_wait
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        checkOutput("br2", 1'b1, 1'b1, 1'b1, 1'b1, 2'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        checkOutput("flush_wait1", 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        checkOutput("flush_wait2", 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
        quiet();
        checkOutput("flush_resume", 1'b1, 1'b1, 1'b1, 1'b0, 2'd2);
        quiet();
        checkOutput("flush_resume_run", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);

        // mem_wait for 3 cycles while mc_cnt=2, then 3 remaining stall cycles
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        checkOutput("mw_mc_issue", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
        quiet();
        checkOutput("mw_mc_stall_cnt3", 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
            checkOutput($sformatf("mw_freeze%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
        end
        for (int i = 0; i < 3; i++) begin
            quiet();
            checkOutput($sformatf("mw_stall_rest%0d", i), 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
        end
        quiet();
        checkOutput("mw_mc_done", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);

        // mem_wait outranks load-use and branch
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0);
        checkOutput("mw_over_lu", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        checkOutput("mw_over_br", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        quiet();
        checkOutput("mw_over_br_next", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);

        // Reset mid-stall aborts it
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        checkOutput("rst_mc_issue", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
        quiet();
        checkOutput("rst_mc_stall", 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        checkOutput("rst_mid_stall", 1'b0, 1'b0, 1'b1, 1'b1, 2'd1);
        quiet();
        checkOutput("rst_mid_stall_after", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
